// File: rtl/dilithium_pkg.sv
// Dilithium modulus, coefficient width and operation-mode encoding shared by the NTT datapath blocks.
package dilithium_pkg;

    localparam int unsigned Q       = 8380417;
    localparam int unsigned INV2    = 4190209;
    localparam int unsigned COEFF_W = 24;

    typedef enum logic [2:0] {
        MODE_FWD  = 3'd0,
        MODE_INV  = 3'd1,
        MODE_MULT = 3'd2,
        MODE_ADD  = 3'd3,
        MODE_SUB  = 3'd4
    } mode_e;

endpackage

// File: rtl/ntt_butterfly_pair_if.sv
// Operand/result bundle of ntt_butterfly_pair: four coefficient lanes and two twiddles in, four lanes out.
interface ntt_butterfly_pair_if;
    import dilithium_pkg::COEFF_W;

    logic                   valid_in;
    logic [2:0]             mode;
    logic [4*COEFF_W-1:0]   data_in;
    logic [2*COEFF_W-1:0]   w_in;
    logic                   valid_out;
    logic [4*COEFF_W-1:0]   data_out;

    modport master (
        output valid_in, mode, data_in, w_in,
        input  valid_out, data_out
    );

    modport slave (
        input  valid_in, mode, data_in, w_in,
        output valid_out, data_out
    );

endinterface

// File: rtl/ntt_modmul.sv
// 24x24 multiply reduced mod Q; latency 2 enabled cycles, en=0 holds both stages.
module ntt_modmul
    import dilithium_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [COEFF_W-1:0] a_i,
    input  logic [COEFF_W-1:0] b_i,
    output logic [COEFF_W-1:0] p_o
);
    localparam int unsigned PW = 2 * COEFF_W;

    logic [PW-1:0]      prod_q;
    logic [COEFF_W-1:0] red_d;
    logic [COEFF_W-1:0] red_q;

    // Q = 2^23 - 2^13 + 1, so 2^23 == 2^13 - 1: fold bits above 23 back down.
    // Three folds bring any 48-bit product below 2Q, leaving one conditional subtract.
    function automatic logic [PW-1:0] fold(input logic [PW-1:0] x);
        logic [PW-1:0] hi;
        hi = x >> 23;
        return (hi << 13) - hi + {{(PW-23){1'b0}}, x[22:0]};
    endfunction

    always_comb begin
        logic [PW-1:0] v;
        v = fold(fold(fold(prod_q)));
        if (v >= PW'(Q)) begin
            v = v - PW'(Q);
        end
        red_d = COEFF_W'(v);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            red_q  <= '0;
        end else if (en) begin
            prod_q <= PW'(a_i) * PW'(b_i);
            red_q  <= red_d;
        end
    end

    assign p_o = red_q;

endmodule

// File: rtl/ntt_butterfly_pair.sv
// Two independent Dilithium butterflies (FWD/INV NTT, MULT, ADD, SUB) over four 24-bit lanes.
// Fixed 4 enabled-cycle latency, one word per enabled cycle; en=0 freezes every stage.
module ntt_butterfly_pair #(
    parameter int unsigned Q       = dilithium_pkg::Q,
    parameter int unsigned LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    ntt_butterfly_pair_if.slave bus
);
    import dilithium_pkg::COEFF_W;
    import dilithium_pkg::mode_e;
    import dilithium_pkg::MODE_FWD;
    import dilithium_pkg::MODE_INV;
    import dilithium_pkg::MODE_MULT;
    import dilithium_pkg::MODE_ADD;
    import dilithium_pkg::MODE_SUB;

    localparam int unsigned W  = COEFF_W;
    localparam int unsigned W1 = W + 1;
    localparam logic [W:0]  QX = W1'(Q);

    typedef logic [1:0][W-1:0] pair_t;

    mode_e              mode_d1, mode_q1, mode_q2, mode_q3;
    pair_t              keep_d1, keep_q1, keep_q2, keep_q3;
    pair_t              mx_d1, mx_q1, my_d1, my_q1;
    pair_t              mm_p;
    logic [4*W-1:0]     data_d, data_q;
    logic [LATENCY-1:0] vld_q;

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QX) s = s - QX;
        return W'(s);
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (x < y) d = d + QX;
        return W'(d);
    endfunction

    // Multiply by 2^-1 mod Q: odd values borrow a Q to become even first.
    function automatic logic [W-1:0] half(input logic [W-1:0] x);
        logic [W:0] s;
        s = {1'b0, x} + (x[0] ? QX : '0);
        return W'(s >> 1);
    endfunction

    // S1: INV pre-add/sub, ADD/SUB result, multiplier operand select.
    always_comb begin
        logic [W-1:0] a, b;
        a       = '0;
        b       = '0;
        mode_d1 = mode_e'(bus.mode);
        keep_d1 = '0;
        mx_d1   = '0;
        my_d1   = '0;
        for (int i = 0; i < 2; i++) begin
            a        = bus.data_in[2*i*W +: W];
            b        = bus.data_in[(2*i+1)*W +: W];
            mx_d1[i] = b;
            my_d1[i] = bus.w_in[i*W +: W];
            case (mode_d1)
                MODE_FWD, MODE_MULT: keep_d1[i] = a;
                MODE_INV: begin
                    keep_d1[i] = mod_add(a, b);
                    mx_d1[i]   = mod_sub(a, b);
                end
                MODE_ADD: keep_d1[i] = mod_add(a, b);
                MODE_SUB: keep_d1[i] = mod_sub(a, b);
                default:  keep_d1[i] = '0;
            endcase
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_mul
        ntt_modmul u_mul (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .a_i (mx_q1[g]),
            .b_i (my_q1[g]),
            .p_o (mm_p[g])
        );
    end

    // S4: FWD post-add/sub, INV halving, result packing.
    always_comb begin
        logic [W-1:0] kv, mv, ra, rb;
        kv     = '0;
        mv     = '0;
        ra     = '0;
        rb     = '0;
        data_d = '0;
        for (int i = 0; i < 2; i++) begin
            kv = keep_q3[i];
            mv = mm_p[i];
            ra = '0;
            rb = '0;
            case (mode_q3)
                MODE_FWD: begin
                    ra = mod_add(kv, mv);
                    rb = mod_sub(kv, mv);
                end
                MODE_INV: begin
                    ra = half(kv);
                    rb = half(mv);
                end
                MODE_MULT: begin
                    ra = kv;
                    rb = mv;
                end
                MODE_ADD, MODE_SUB: ra = kv;
                default: ;
            endcase
            data_d[2*i*W +: W]     = ra;
            data_d[(2*i+1)*W +: W] = rb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q1 <= MODE_FWD;
            mode_q2 <= MODE_FWD;
            mode_q3 <= MODE_FWD;
            keep_q1 <= '0;
            keep_q2 <= '0;
            keep_q3 <= '0;
            mx_q1   <= '0;
            my_q1   <= '0;
            data_q  <= '0;
            vld_q   <= '0;
        end else if (en) begin
            mode_q1 <= mode_d1;
            mode_q2 <= mode_q1;
            mode_q3 <= mode_q2;
            keep_q1 <= keep_d1;
            keep_q2 <= keep_q1;
            keep_q3 <= keep_q2;
            mx_q1   <= mx_d1;
            my_q1   <= my_d1;
            data_q  <= data_d;
            vld_q   <= {vld_q[LATENCY-2:0], bus.valid_in};
        end
    end

    assign bus.valid_out = vld_q[LATENCY-1];
    assign bus.data_out  = data_q;

endmodule

// File: tb/tb_ntt_butterfly_pair.sv
// Directed bench for ntt_butterfly_pair: hand-computed vectors for every mode, stall and reset behaviour.
module tb_ntt_butterfly_pair;
    import dilithium_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic en;
    int   tests = 0;
    int   fails = 0;

    ntt_butterfly_pair_if bus ();

    ntt_butterfly_pair dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] word4(input int unsigned a0, input int unsigned b0,
                                          input int unsigned a1, input int unsigned b1);
        return {24'(b1), 24'(a1), 24'(b0), 24'(a0)};
    endfunction

    function automatic logic [47:0] tw(input int unsigned w0, input int unsigned w1);
        return {24'(w1), 24'(w0)};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input int unsigned m, input logic [95:0] d, input logic [47:0] w);
        bus.valid_in = v;
        bus.mode     = 3'(m);
        bus.data_in  = d;
        bus.w_in     = w;
    endtask

    task automatic idle();
        drive(1'b0, 0, '0, '0);
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic exp);
        chk(tag, {95'd0, bus.valid_out}, {95'd0, exp});
    endtask

    task automatic chk_d(input string tag, input logic [95:0] exp);
        chk(tag, bus.data_out, exp);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        idle();
        tick();
        tick();
        chk_v("reset_vld", 1'b0);
        chk_d("reset_dat", '0);
        rst = 1'b0;

        // Single FWD word: 1 + 3*2 = 7, 1 - 6 = -5
        drive(1'b1, MODE_FWD, word4(1, 2, 1, 2), tw(3, 3));
        tick(); idle();
        tick(); tick();
        chk_v("fwd_not_early", 1'b0);
        tick();
        chk_v("fwd_vld", 1'b1);
        chk_d("fwd_dat", word4(7, 8380412, 7, 8380412));
        tick();
        chk_v("fwd_vld_drop", 1'b0);

        // FWD wrap-around in both butterflies
        drive(1'b1, MODE_FWD, word4(8380416, 1, 0, 8380416), tw(1, 8380416));
        tick(); idle();
        tick(); tick(); tick();
        chk_v("fwd_wrap_vld", 1'b1);
        chk_d("fwd_wrap_dat", word4(0, 8380415, 1, 8380416));

        // INV, MULT with large products, reserved mode, back to back
        drive(1'b1, MODE_INV, word4(1, 3, 3, 1), tw(1, 5));
        tick();
        drive(1'b1, MODE_MULT, word4(0, 4194304, 0, 4194304), tw(2, 4194304));
        tick();
        drive(1'b1, 6, word4(1, 2, 3, 4), tw(5, 6));
        tick(); idle();
        tick();
        chk_v("inv_vld", 1'b1);
        chk_d("inv_dat", word4(2, 8380416, 2, 5));
        tick();
        chk_v("mult_big_vld", 1'b1);
        chk_d("mult_big_dat", word4(0, 8191, 0, 6297599));
        tick();
        chk_v("reserved_vld", 1'b1);
        chk_d("reserved_dat", '0);

        // Mixed modes on consecutive cycles
        drive(1'b1, MODE_FWD, word4(5, 1, 10, 0), tw(2, 9));
        tick();
        drive(1'b1, MODE_MULT, word4(11, 7, 8380416, 8380416), tw(2, 8380416));
        tick();
        drive(1'b1, MODE_ADD, word4(8380416, 5, 100, 200), tw(123, 456));
        tick();
        drive(1'b1, MODE_SUB, word4(0, 1, 200, 100), tw(7, 8));
        tick(); idle();
        chk_v("mix_fwd_vld", 1'b1);
        chk_d("mix_fwd_dat", word4(7, 3, 10, 10));
        tick();
        chk_v("mix_mult_vld", 1'b1);
        chk_d("mix_mult_dat", word4(11, 14, 8380416, 1));
        tick();
        chk_v("mix_add_vld", 1'b1);
        chk_d("mix_add_dat", word4(4, 0, 300, 0));
        tick();
        chk_v("mix_sub_vld", 1'b1);
        chk_d("mix_sub_dat", word4(8380416, 0, 100, 0));
        tick();
        chk_v("mix_end_vld", 1'b0);

        // ADD stream with a 3-cycle stall; inputs offered during the stall must be ignored
        drive(1'b1, MODE_ADD, word4(1, 2, 3, 4), tw(0, 0));
        tick();
        drive(1'b1, MODE_ADD, word4(10, 20, 30, 40), tw(0, 0));
        tick();
        drive(1'b1, MODE_ADD, word4(8380400, 20, 5, 5), tw(0, 0));
        tick(); idle();
        tick();
        chk_v("stall_a1_vld", 1'b1);
        chk_d("stall_a1_dat", word4(3, 0, 7, 0));
        en = 1'b0;
        drive(1'b1, MODE_FWD, word4(9, 9, 9, 9), tw(9, 9));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_v("stall_hold_vld", 1'b1);
            chk_d("stall_hold_dat", word4(3, 0, 7, 0));
        end
        en = 1'b1;
        idle();
        tick();
        chk_v("stall_a2_vld", 1'b1);
        chk_d("stall_a2_dat", word4(30, 0, 70, 0));
        tick();
        chk_v("stall_a3_vld", 1'b1);
        chk_d("stall_a3_dat", word4(3, 0, 10, 0));
        tick();
        chk_v("stall_end_vld", 1'b0);

        // Reset with three words in flight, then a fresh word
        drive(1'b1, MODE_FWD, word4(1, 2, 1, 2), tw(3, 3));
        tick();
        drive(1'b1, MODE_ADD, word4(1, 1, 1, 1), tw(0, 0));
        tick();
        drive(1'b1, MODE_MULT, word4(5, 5, 5, 5), tw(5, 5));
        tick(); idle();
        rst = 1'b1;
        tick();
        chk_v("rst_flush_vld", 1'b0);
        chk_d("rst_flush_dat", '0);
        rst = 1'b0;
        drive(1'b1, MODE_SUB, word4(0, 1, 0, 0), tw(0, 0));
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            chk_v("rst_gap_vld", 1'b0);
            chk_d("rst_gap_dat", '0);
            tick();
        end
        chk_v("rst_new_vld", 1'b1);
        chk_d("rst_new_dat", word4(8380416, 0, 0, 0));
        tick();
        chk_v("rst_new_drop", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
